// File: rtl/control_unit.sv
// Step sequencer and control-strobe decode for a multicycle
// processor: T0 fetch, then one (mv/mvi) or three (ALU) steps.
module control_unit (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       Run,
   input  logic [8:0] IR,
   output logic       IRin,
   output logic [7:0] Rin,
   output logic [7:0] Rout,
   output logic       DINout,
   output logic       Gout,
   output logic       Ain,
   output logic       Gin,
   output logic [2:0] AluOp,
   output logic       Done,
   output logic       Busy
);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } step_t;

   step_t step;
   step_t step_nxt;

   logic [2:0] op;
   logic [2:0] x;
   logic [2:0] y;
   logic [7:0] x_sel;
   logic [7:0] y_sel;
   logic       is_mv;
   logic       is_mvi;
   logic       is_alu;
   logic [2:0] alu_code;

   assign op     = IR[8:6];
   assign x      = IR[5:3];
   assign y      = IR[2:0];
   assign x_sel  = 8'b1 << x;
   assign y_sel  = 8'b1 << y;
   assign is_mv  = (op == 3'b000);
   assign is_mvi = (op == 3'b001);
   assign is_alu = op[2] | op[1];

   always_comb begin
      alu_code = 3'b000;
      unique case (op)
         3'b010:  alu_code = 3'b000;
         3'b011:  alu_code = 3'b001;
         3'b100:  alu_code = 3'b010;
         3'b101:  alu_code = 3'b011;
         3'b110:  alu_code = 3'b100;
         3'b111:  alu_code = 3'b101;
         default: alu_code = 3'b000;
      endcase
   end

   // Non-ALU opcodes never reach T2/T3 normally; fall back to T0.
   always_comb begin
      step_nxt = T0;
      unique case (step)
         T0: step_nxt = Run ? T1 : T0;
         T1: step_nxt = is_alu ? T2 : T0;
         T2: step_nxt = is_alu ? T3 : T0;
         T3: step_nxt = T0;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)
         step <= T0;
      else
         step <= step_nxt;
   end

   // Outputs gated by Resetn so IRin cannot follow Run while held in reset.
   always_comb begin
      IRin   = 1'b0;
      Rin    = 8'h00;
      Rout   = 8'h00;
      DINout = 1'b0;
      Gout   = 1'b0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      AluOp  = 3'b000;
      Done   = 1'b0;
      Busy   = 1'b0;
      if (Resetn) begin
         Busy = (step != T0);
         if (is_alu && step != T0)
            AluOp = alu_code;
         unique case (step)
            T0: IRin = Run;
            T1: begin
               if (is_mv) begin
                  Rout = y_sel;
                  Rin  = x_sel;
                  Done = 1'b1;
               end else if (is_mvi) begin
                  DINout = 1'b1;
                  Rin    = x_sel;
                  Done   = 1'b1;
               end else begin
                  Rout = x_sel;
                  Ain  = 1'b1;
               end
            end
            T2: begin
               if (is_alu) begin
                  Rout = y_sel;
                  Gin  = 1'b1;
               end
            end
            T3: begin
               if (is_alu) begin
                  Gout = 1'b1;
                  Rin  = x_sel;
                  Done = 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-step output vectors plus
// bus-exclusivity and Done-pulse invariants on every cycle.
module tb_control_unit;

   logic       Clock;
   logic       Resetn;
   logic       Run;
   logic [8:0] IR;
   logic       IRin;
   logic [7:0] Rin;
   logic [7:0] Rout;
   logic       DINout;
   logic       Gout;
   logic       Ain;
   logic       Gin;
   logic [2:0] AluOp;
   logic       Done;
   logic       Busy;

   control_unit dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .Run    (Run),
      .IR     (IR),
      .IRin   (IRin),
      .Rin    (Rin),
      .Rout   (Rout),
      .DINout (DINout),
      .Gout   (Gout),
      .Ain    (Ain),
      .Gin    (Gin),
      .AluOp  (AluOp),
      .Done   (Done),
      .Busy   (Busy)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int   errors;
   int   checks;
   int   done_cnt;
   logic prev_done;

   localparam logic [25:0] ZERO = 26'd0;

   logic [25:0] obs;
   assign obs = {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AluOp, Done, Busy};

   function automatic logic [25:0] ex(
      input logic       irin,
      input logic [7:0] rin,
      input logic [7:0] rout,
      input logic       din,
      input logic       gout,
      input logic       ain,
      input logic       gin,
      input logic [2:0] aop,
      input logic       done,
      input logic       busy
   );
      return {irin, rin, rout, din, gout, ain, gin, aop, done, busy};
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // One call per clock cycle: full output vector plus invariants.
   task automatic cyc(input string tag, input logic [25:0] e);
      logic bus_ok;
      logic rin_ok;
      logic done_ok;
      #1;
      chk(tag, {6'd0, obs}, {6'd0, e});
      bus_ok  = ($countones({Rout, DINout, Gout}) <= 1);
      rin_ok  = $onehot0(Rin);
      done_ok = !(prev_done && Done) && (!Done || Busy);
      chk({tag, "_bus"}, {31'd0, bus_ok}, 32'd1);
      chk({tag, "_rin"}, {31'd0, rin_ok}, 32'd1);
      chk({tag, "_done"}, {31'd0, done_ok}, 32'd1);
      if (Done)
         done_cnt++;
      prev_done = Done;
   endtask

   task automatic alu_seq(
      input string      tag,
      input logic [8:0] ir,
      input logic [7:0] rx,
      input logic [7:0] ry,
      input logic [2:0] aop
   );
      tick();
      IR  = ir;
      Run = 1'b1;
      cyc({tag, "_t0"}, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
      tick();
      Run = 1'b0;
      cyc({tag, "_t1"}, ex(0, 8'h00, rx, 0, 0, 1, 0, aop, 0, 1));
      tick();
      cyc({tag, "_t2"}, ex(0, 8'h00, ry, 0, 0, 0, 1, aop, 0, 1));
      tick();
      cyc({tag, "_t3"}, ex(0, rx, 8'h00, 0, 1, 0, 0, aop, 1, 1));
      tick();
      cyc({tag, "_end"}, ZERO);
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      done_cnt  = 0;
      prev_done = 1'b0;
      Resetn    = 1'b0;
      Run       = 1'b1;
      IR        = 9'd0;

      // Reset: Run high must not leak to IRin.
      #2;
      chk("rst_async", {6'd0, obs}, {6'd0, ZERO});
      tick();
      chk("rst_clk", {6'd0, obs}, {6'd0, ZERO});
      Resetn = 1'b1;
      Run    = 1'b0;
      cyc("idle", ZERO);

      // mvi R2
      tick();
      IR  = 9'b001_010_000;
      Run = 1'b1;
      cyc("mvi_t0", ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
      tick();
      Run = 1'b0;
      cyc("mvi_t1", ex(0, 8'h04, 8'h00, 1, 0, 0, 0, 3'b000, 1, 1));
      tick();
      cyc("mvi_end", ZERO);

      // add R1,R3
      alu_seq("add13", 9'b010_001_011, 8'h02, 8'h08, 3'b000);

      // srl R0,R7 then mv R5,R0 with Run held
      tick();
      IR  = 9'b111_000_111;
      Run = 1'b1;
      cyc("b2b_c0", ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
      tick();
      cyc("b2b_c1", ex(0, 8'h00, 8'h01, 0, 0, 1, 0, 3'b101, 0, 1));
      tick();
      cyc("b2b_c2", ex(0, 8'h00, 8'h80, 0, 0, 0, 1, 3'b101, 0, 1));
      tick();
      cyc("b2b_c3", ex(0, 8'h01, 8'h00, 0, 1, 0, 0, 3'b101, 1, 1));
      tick();
      IR = 9'b000_101_000;
      cyc("b2b_c4", ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
      tick();
      Run = 1'b0;
      cyc("b2b_c5", ex(0, 8'h20, 8'h01, 0, 0, 0, 0, 3'b000, 1, 1));
      tick();
      cyc("b2b_c6", ZERO);

      // sub R4,R6 abandoned by reset in T2
      tick();
      IR  = 9'b011_100_110;
      Run = 1'b1;
      cyc("sub_t0", ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
      tick();
      Run = 1'b0;
      cyc("sub_t1", ex(0, 8'h00, 8'h10, 0, 0, 1, 0, 3'b001, 0, 1));
      tick();
      cyc("sub_t2", ex(0, 8'h00, 8'h40, 0, 0, 0, 1, 3'b001, 0, 1));
      #1;
      Resetn = 1'b0;
      #1;
      chk("sub_rst", {6'd0, obs}, {6'd0, ZERO});
      tick();
      Resetn = 1'b1;
      cyc("sub_after", ZERO);
      tick();
      cyc("sub_after2", ZERO);
      alu_seq("subr", 9'b011_100_110, 8'h10, 8'h40, 3'b001);

      // slt R3,R1 with Run toggling mid-instruction
      tick();
      IR  = 9'b101_011_001;
      Run = 1'b1;
      cyc("slt_t0", ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
      tick();
      cyc("slt_t1", ex(0, 8'h00, 8'h08, 0, 0, 1, 0, 3'b011, 0, 1));
      tick();
      Run = 1'b0;
      cyc("slt_t2", ex(0, 8'h00, 8'h02, 0, 0, 0, 1, 3'b011, 0, 1));
      tick();
      Run = 1'b1;
      cyc("slt_t3", ex(0, 8'h08, 8'h00, 0, 1, 0, 0, 3'b011, 1, 1));
      tick();
      Run = 1'b0;
      cyc("slt_end", ZERO);

      // mv R6,R6
      tick();
      IR  = 9'b000_110_110;
      Run = 1'b1;
      cyc("mv66_t0", ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
      tick();
      Run = 1'b0;
      cyc("mv66_t1", ex(0, 8'h40, 8'h40, 0, 0, 0, 0, 3'b000, 1, 1));
      tick();
      cyc("mv66_end", ZERO);

      // add R2,R2, or R7,R0, sll R0,R1
      alu_seq("add22", 9'b010_010_010, 8'h04, 8'h04, 3'b000);
      alu_seq("or70", 9'b100_111_000, 8'h80, 8'h01, 3'b010);
      alu_seq("sll01", 9'b110_000_001, 8'h01, 8'h02, 3'b100);

      // T3 reached with a mvi opcode: strobes low, back to T0
      tick();
      IR  = 9'b010_001_011;
      Run = 1'b1;
      cyc("t3x_t0", ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 0));
      tick();
      Run = 1'b0;
      cyc("t3x_t1", ex(0, 8'h00, 8'h02, 0, 0, 1, 0, 3'b000, 0, 1));
      tick();
      cyc("t3x_t2", ex(0, 8'h00, 8'h08, 0, 0, 0, 1, 3'b000, 0, 1));
      tick();
      IR = 9'b001_001_011;
      cyc("t3x_t3", ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0, 1));
      tick();
      cyc("t3x_end", ZERO);

      chk("done_total", done_cnt, 32'd10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
